// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shared prescaler and period counter, shadowed period/duty/mode.
// Center-aligned counting is built only when PWM_CENTER_ALIGN_EN is defined.
module pwm_bank #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_o
);
  localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_EN     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_POL    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_DUTY   = ADDR_W'(5);
  logic [WIDTH-1:0]  r_presc, r_pcnt, r_period_sh, r_period_act, r_cnt;
  logic [NUM_CH-1:0] r_en, r_pol;
  logic [WIDTH-1:0]  r_duty_sh [NUM_CH];
  logic [WIDTH-1:0]  r_duty_act [NUM_CH];
  logic              w_tick, w_wrap;
  logic [WIDTH-1:0]  w_cnt_nxt, w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [NUM_CH-1:0] w_pwm;
  logic              w_unused;
  assign w_wdata  = wdata_i[WIDTH-1:0];
  assign w_unused = ^wdata_i;
  // >= lets a lowered PRESCALE tick at once instead of wrapping the prescaler
  assign w_tick   = r_pcnt >= r_presc;
`ifdef PWM_CENTER_ALIGN_EN
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  logic r_ctrl_sh, r_ctrl_act, r_dir;
  logic w_center, w_down;
  assign w_center  = r_ctrl_act && r_period_act != '0;
  assign w_down    = w_center && (r_dir || r_cnt == r_period_act);
  assign w_cnt_nxt = w_down ? r_cnt - WIDTH'(1) : (r_cnt == r_period_act) ? '0 : r_cnt + WIDTH'(1);
  assign w_wrap    = w_tick && (w_down ? r_cnt == WIDTH'(1) : (!w_center && r_cnt == r_period_act));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_sh  <= 1'b0;
      r_ctrl_act <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      if (wr_i && addr_i == A_CTRL) r_ctrl_sh <= wdata_i[0];
      if (w_wrap) r_ctrl_act <= r_ctrl_sh;
      if (w_tick) r_dir <= w_down && !w_wrap;
    end
  end
`else
  assign w_cnt_nxt = (r_cnt == r_period_act) ? '0 : r_cnt + WIDTH'(1);
  assign w_wrap    = w_tick && r_cnt == r_period_act;
`endif
  always_comb begin
    w_rdata = '0;
    if (addr_i == A_PRESC)  w_rdata = DATA_W'(r_presc);
    if (addr_i == A_PERIOD) w_rdata = DATA_W'(r_period_sh);
    if (addr_i == A_EN)     w_rdata = DATA_W'(r_en);
    if (addr_i == A_POL)    w_rdata = DATA_W'(r_pol);
    for (int k = 0; k < NUM_CH; k++)
      if (addr_i == A_DUTY + ADDR_W'(k)) w_rdata = DATA_W'(r_duty_sh[k]);
`ifdef PWM_CENTER_ALIGN_EN
    if (addr_i == A_CTRL)   w_rdata = DATA_W'(r_ctrl_sh);
`endif
  end
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_pwm[i] = r_en[i] ? ((r_cnt < r_duty_act[i]) ^ r_pol[i]) : r_pol[i];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_duty_sh[i]  <= '0;
          r_duty_act[i] <= '0;
        end else begin
          if (wr_i && addr_i == A_DUTY + ADDR_W'(i)) r_duty_sh[i] <= w_wdata;
          if (w_wrap) r_duty_act[i] <= r_duty_sh[i];
        end
      end
    end
  endgenerate
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc      <= '0;
      r_period_sh  <= '1;
      r_period_act <= '1;
      r_en         <= '0;
      r_pol        <= '0;
      r_pcnt       <= '0;
      r_cnt        <= '0;
      pwm_o        <= '0;
      period_o     <= 1'b0;
      rdata_o      <= '0;
    end else begin
      if (wr_i && addr_i == A_PRESC)  r_presc     <= w_wdata;
      if (wr_i && addr_i == A_PERIOD) r_period_sh <= w_wdata;
      if (wr_i && addr_i == A_EN)     r_en        <= wdata_i[NUM_CH-1:0];
      if (wr_i && addr_i == A_POL)    r_pol       <= wdata_i[NUM_CH-1:0];
      r_pcnt <= w_tick ? '0 : r_pcnt + WIDTH'(1);
      if (w_tick) r_cnt <= w_cnt_nxt;
      if (w_wrap) r_period_act <= r_period_sh;
      pwm_o    <= w_pwm;
      period_o <= w_wrap;
      rdata_o  <= w_rdata;
    end
  end
endmodule
